// File: rtl/audio_packet_scheduler.sv
// Packet-slot scheduler for HDMI data islands. Buffers stereo sample pairs,
// raises periodic ACR requests and per-frame InfoFrame requests, and on each
// packet_enable slot picks one packet type with a fairness cap on audio runs.
module audio_packet_scheduler #(
  parameter int unsigned ACR_INTERVAL    = 25200,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned AUDIO_BIT_WIDTH = 24
) (
  input  logic                                clk_pixel,
  input  logic                                reset,
  input  logic                                audio_sample_valid,
  input  logic [1:0][AUDIO_BIT_WIDTH-1:0]     audio_sample_word_in,
  input  logic                                frame_start,
  input  logic                                packet_enable,
  output logic [7:0]                          packet_type,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0]     audio_sample_word_out,
  output logic                                sample_packet_strobe,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                overflow
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(ACR_INTERVAL);

  localparam logic [7:0] PktNull  = 8'h00;
  localparam logic [7:0] PktAcr   = 8'h01;
  localparam logic [7:0] PktAudio = 8'h02;
  localparam logic [7:0] PktAvi   = 8'h82;
  localparam logic [7:0] PktAif   = 8'h84;

  typedef enum logic [2:0] {
    SelNone,
    SelNull,
    SelAcr,
    SelAudio,
    SelAvi,
    SelAif
  } sel_e;

  typedef logic [1:0][AUDIO_BIT_WIDTH-1:0] pair_t;

  // State
  pair_t              mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]    level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               acr_pending_q, acr_pending_d;
  logic               avi_pending_q, avi_pending_d;
  logic               aif_pending_q, aif_pending_d;
  logic [1:0]         streak_q, streak_d;
  logic [7:0]         pkt_type_q, pkt_type_d;
  pair_t              word_out_q, word_out_d;
  logic               strobe_q, strobe_d;

  sel_e               sel;
  logic               fifo_empty;
  logic               fifo_full;
  logic               timer_wrap;
  logic               pop;
  logic               push_accept;

  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == LvlW'(FIFO_DEPTH));
  assign timer_wrap  = (timer_q == TimerW'(ACR_INTERVAL - 1));
  assign pop         = (sel == SelAudio);
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign push_accept = audio_sample_valid && (!fifo_full || pop);

  // Slot arbitration on the pre-update pending flags and FIFO contents.
  always_comb begin
    sel = SelNone;
    if (packet_enable) begin
      if (acr_pending_q) begin
        sel = SelAcr;
      end else if ((avi_pending_q || aif_pending_q) && (streak_q == 2'd2)) begin
        sel = avi_pending_q ? SelAvi : SelAif;
      end else if (!fifo_empty) begin
        sel = SelAudio;
      end else if (avi_pending_q) begin
        sel = SelAvi;
      end else if (aif_pending_q) begin
        sel = SelAif;
      end else begin
        sel = SelNull;
      end
    end
  end

  // Next-state for timer, request flags, FIFO bookkeeping and outputs.
  always_comb begin
    timer_d       = timer_wrap ? '0 : timer_q + TimerW'(1);
    acr_pending_d = acr_pending_q;
    avi_pending_d = avi_pending_q;
    aif_pending_d = aif_pending_q;
    streak_d      = streak_q;
    pkt_type_d    = pkt_type_q;
    word_out_d    = word_out_q;
    strobe_d      = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    overflow_d    = overflow_q;

    unique case (sel)
      SelAcr: begin
        pkt_type_d    = PktAcr;
        acr_pending_d = 1'b0;
        streak_d      = 2'd0;
      end
      SelAvi: begin
        pkt_type_d    = PktAvi;
        avi_pending_d = 1'b0;
        streak_d      = 2'd0;
      end
      SelAif: begin
        pkt_type_d    = PktAif;
        aif_pending_d = 1'b0;
        streak_d      = 2'd0;
      end
      SelAudio: begin
        pkt_type_d = PktAudio;
        word_out_d = mem_q[rd_ptr_q];
        strobe_d   = 1'b1;
        streak_d   = (streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1;
      end
      SelNull: begin
        pkt_type_d = PktNull;
        streak_d   = 2'd0;
      end
      default: ;
    endcase

    // Fresh requests override a same-cycle clear.
    if (timer_wrap) acr_pending_d = 1'b1;
    if (frame_start) begin
      avi_pending_d = 1'b1;
      aif_pending_d = 1'b1;
    end

    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (audio_sample_valid && !push_accept) overflow_d = 1'b1;

    if (push_accept && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_accept && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      timer_q       <= '0;
      acr_pending_q <= 1'b0;
      avi_pending_q <= 1'b1;
      aif_pending_q <= 1'b1;
      streak_q      <= 2'd0;
      pkt_type_q    <= PktNull;
      word_out_q    <= '0;
      strobe_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      acr_pending_q <= acr_pending_d;
      avi_pending_q <= avi_pending_d;
      aif_pending_q <= aif_pending_d;
      streak_q      <= streak_d;
      pkt_type_q    <= pkt_type_d;
      word_out_q    <= word_out_d;
      strobe_q      <= strobe_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
    end
  end

  // Sample storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk_pixel) begin
    if (!reset && push_accept) begin
      mem_q[wr_ptr_q] <= audio_sample_word_in;
    end
  end

  assign packet_type           = pkt_type_q;
  assign audio_sample_word_out = word_out_q;
  assign sample_packet_strobe  = strobe_q;
  assign fifo_level            = level_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_audio_packet_scheduler.sv
// Bench for audio_packet_scheduler. Instance A (long ACR period) is checked
// against a table of hand-derived expectations; instance B (ACR period 8) is
// checked every cycle against a queue-based reference model.
module tb_audio_packet_scheduler;

  localparam int unsigned W      = 24;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ACR_A  = 1000;
  localparam int unsigned ACR_B  = 8;

  logic               clk_pixel = 1'b0;
  logic               reset = 1'b0;
  logic               audio_sample_valid = 1'b0;
  logic [1:0][W-1:0]  audio_sample_word_in = '0;
  logic               frame_start = 1'b0;
  logic               packet_enable = 1'b0;

  logic [7:0]         a_type, b_type;
  logic [1:0][W-1:0]  a_word, b_word;
  logic               a_stb, b_stb;
  logic [2:0]         a_level, b_level;
  logic               a_ovf, b_ovf;

  always #5 clk_pixel = ~clk_pixel;

  audio_packet_scheduler #(
    .ACR_INTERVAL(ACR_A), .FIFO_DEPTH(DEPTH), .AUDIO_BIT_WIDTH(W)
  ) dut_a (
    .clk_pixel(clk_pixel), .reset(reset), .audio_sample_valid(audio_sample_valid),
    .audio_sample_word_in(audio_sample_word_in), .frame_start(frame_start),
    .packet_enable(packet_enable), .packet_type(a_type), .audio_sample_word_out(a_word),
    .sample_packet_strobe(a_stb), .fifo_level(a_level), .overflow(a_ovf)
  );

  audio_packet_scheduler #(
    .ACR_INTERVAL(ACR_B), .FIFO_DEPTH(DEPTH), .AUDIO_BIT_WIDTH(W)
  ) dut_b (
    .clk_pixel(clk_pixel), .reset(reset), .audio_sample_valid(audio_sample_valid),
    .audio_sample_word_in(audio_sample_word_in), .frame_start(frame_start),
    .packet_enable(packet_enable), .packet_type(b_type), .audio_sample_word_out(b_word),
    .sample_packet_strobe(b_stb), .fifo_level(b_level), .overflow(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for instance B ----------------
  logic [2*W-1:0] m_q[$];
  int unsigned    m_cyc;
  bit             m_acr, m_avi, m_aif, m_ovf, m_stb, m_live;
  int             m_streak;
  logic [7:0]     m_type;
  logic [2*W-1:0] m_word;
  int             m_acr_cnt;

  task automatic model_step(input bit rst, input bit v, input logic [2*W-1:0] w,
                            input bit f, input bit e);
    bit wrap;
    if (rst) begin
      m_q.delete();
      m_cyc = 0; m_acr = 0; m_avi = 1; m_aif = 1; m_streak = 0; m_ovf = 0;
      m_type = 8'h00; m_word = '0; m_stb = 0; m_live = 1;
      return;
    end
    wrap  = (m_cyc % ACR_B) == ACR_B - 1;
    m_stb = 0;
    if (e) begin
      if (m_acr) begin
        m_type = 8'h01; m_acr = 0; m_streak = 0; m_acr_cnt++;
      end else if ((m_avi || m_aif) && m_streak == 2) begin
        if (m_avi) begin m_type = 8'h82; m_avi = 0; end
        else begin m_type = 8'h84; m_aif = 0; end
        m_streak = 0;
      end else if (m_q.size() > 0) begin
        m_type = 8'h02; m_word = m_q.pop_front(); m_stb = 1;
        m_streak = (m_streak >= 2) ? 2 : m_streak + 1;
      end else if (m_avi) begin
        m_type = 8'h82; m_avi = 0; m_streak = 0;
      end else if (m_aif) begin
        m_type = 8'h84; m_aif = 0; m_streak = 0;
      end else begin
        m_type = 8'h00; m_streak = 0;
      end
    end
    // Pop above happens first, so a push into a full FIFO that pops succeeds.
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else m_ovf = 1;
    end
    if (wrap) m_acr = 1;
    if (f) begin m_avi = 1; m_aif = 1; end
    m_cyc++;
  endtask

  // One clock: drive inputs, advance the model, compare instance B.
  task automatic step(input bit rst, input bit v, input logic [2*W-1:0] w,
                      input bit f, input bit e);
    reset = rst; audio_sample_valid = v; audio_sample_word_in = w;
    frame_start = f; packet_enable = e;
    @(posedge clk_pixel);
    model_step(rst, v, w, f, e);
    #1;
    if (m_live) begin
      chk("b_type", b_type, m_type);
      chk("b_word", b_word, m_word);
      chk("b_strobe", b_stb, m_stb);
      chk("b_level", b_level, m_q.size());
      chk("b_overflow", b_ovf, m_ovf);
    end
  endtask

  // ---------------- directed table for instance A ----------------
  typedef struct {
    bit             rst, v, f, e;
    logic [2*W-1:0] win;
    logic [7:0]     e_type;
    int             e_level;
    bit             e_stb;
    logic [2*W-1:0] e_word;
    bit             e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2*W-1:0] pr(input logic [W-1:0] l, input logic [W-1:0] r);
    return {r, l};
  endfunction

  task automatic add(input bit rst, input bit v, input logic [2*W-1:0] win, input bit f,
                     input bit e, input logic [7:0] et, input int el, input bit es,
                     input logic [2*W-1:0] ew, input bit eo);
    vec_t t;
    t.rst = rst; t.v = v; t.win = win; t.f = f; t.e = e;
    t.e_type = et; t.e_level = el; t.e_stb = es; t.e_word = ew; t.e_ovf = eo;
    tbl.push_back(t);
  endtask

  initial begin
    logic [2*W-1:0] p1, p2, p3, lastw;
    int acr_seen;

    p1 = pr(24'h000001, 24'h100001);
    p2 = pr(24'h000002, 24'h100002);
    p3 = pr(24'h000003, 24'h100003);

    // Reset then idle: AVI, AIF, Null.
    add(1, 0, '0, 0, 0, 8'h00, 0, 0, '0, 0);
    add(0, 0, '0, 0, 0, 8'h00, 0, 0, '0, 0);
    add(0, 0, '0, 0, 1, 8'h82, 0, 0, '0, 0);
    add(0, 0, '0, 0, 0, 8'h82, 0, 0, '0, 0);
    add(0, 0, '0, 0, 1, 8'h84, 0, 0, '0, 0);
    add(0, 0, '0, 0, 0, 8'h84, 0, 0, '0, 0);
    add(0, 0, '0, 0, 1, 8'h00, 0, 0, '0, 0);
    add(0, 0, '0, 0, 0, 8'h00, 0, 0, '0, 0);
    // Audio drain.
    add(0, 1, p1, 0, 0, 8'h00, 1, 0, '0, 0);
    add(0, 1, p2, 0, 0, 8'h00, 2, 0, '0, 0);
    add(0, 1, p3, 0, 0, 8'h00, 3, 0, '0, 0);
    add(0, 0, '0, 0, 1, 8'h02, 2, 1, p1, 0);
    add(0, 0, '0, 0, 1, 8'h02, 1, 1, p2, 0);
    add(0, 0, '0, 0, 1, 8'h02, 0, 1, p3, 0);
    add(0, 0, '0, 0, 1, 8'h00, 0, 0, p3, 0);
    // Fairness: two audio, AVI, two audio, AIF.
    for (int i = 0; i < 4; i++)
      add(0, 1, pr(24'h11 + i, 24'h21 + i), 0, 0, 8'h00, i + 1, 0, p3, 0);
    add(0, 0, '0, 1, 0, 8'h00, 4, 0, p3, 0);
    add(0, 0, '0, 0, 1, 8'h02, 3, 1, pr(24'h11, 24'h21), 0);
    add(0, 0, '0, 0, 1, 8'h02, 2, 1, pr(24'h12, 24'h22), 0);
    add(0, 0, '0, 0, 1, 8'h82, 2, 0, pr(24'h12, 24'h22), 0);
    add(0, 0, '0, 0, 1, 8'h02, 1, 1, pr(24'h13, 24'h23), 0);
    add(0, 0, '0, 0, 1, 8'h02, 0, 1, pr(24'h14, 24'h24), 0);
    add(0, 0, '0, 0, 1, 8'h84, 0, 0, pr(24'h14, 24'h24), 0);
    // Overflow, then push+pop on a full FIFO.
    lastw = pr(24'h14, 24'h24);
    for (int i = 0; i < 4; i++)
      add(0, 1, pr(24'h31 + i, 24'h41 + i), 0, 0, 8'h84, i + 1, 0, lastw, 0);
    add(0, 1, pr(24'h35, 24'h45), 0, 0, 8'h84, 4, 0, lastw, 1);
    add(0, 1, pr(24'h36, 24'h46), 0, 1, 8'h02, 4, 1, pr(24'h31, 24'h41), 1);
    add(0, 0, '0, 0, 1, 8'h02, 3, 1, pr(24'h32, 24'h42), 1);
    add(0, 0, '0, 0, 1, 8'h02, 2, 1, pr(24'h33, 24'h43), 1);
    add(0, 0, '0, 0, 1, 8'h02, 1, 1, pr(24'h34, 24'h44), 1);
    add(0, 0, '0, 0, 1, 8'h02, 0, 1, pr(24'h36, 24'h46), 1);
    // Reset mid-operation wins over simultaneous inputs.
    lastw = pr(24'h36, 24'h46);
    for (int i = 0; i < 3; i++)
      add(0, 1, pr(24'h51 + i, 24'h61 + i), 0, 0, 8'h02, i + 1, 0, lastw, 1);
    add(1, 1, pr(24'h77, 24'h88), 1, 1, 8'h00, 0, 0, '0, 0);
    add(0, 0, '0, 0, 0, 8'h00, 0, 0, '0, 0);
    add(0, 0, '0, 0, 1, 8'h82, 0, 0, '0, 0);
    add(0, 0, '0, 0, 1, 8'h84, 0, 0, '0, 0);

    m_live = 0;
    m_acr_cnt = 0;
    @(negedge clk_pixel);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].win, tbl[i].f, tbl[i].e);
      chk($sformatf("a_type[%0d]", i), a_type, tbl[i].e_type);
      chk($sformatf("a_level[%0d]", i), a_level, tbl[i].e_level);
      chk($sformatf("a_strobe[%0d]", i), a_stb, tbl[i].e_stb);
      chk($sformatf("a_word[%0d]", i), a_word, tbl[i].e_word);
      chk($sformatf("a_overflow[%0d]", i), a_ovf, tbl[i].e_ovf);
    end

    // ACR priority on instance B: keep the FIFO busy, select every 3 cycles.
    step(1, 0, '0, 0, 0);
    m_acr_cnt = 0;
    acr_seen  = 0;
    step(0, 1, pr(24'hA0, 24'hB0), 0, 0);
    step(0, 1, pr(24'hA1, 24'hB1), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, pr(24'hC0 + i, 24'hD0 + i), 0, 0);
      step(0, 0, '0, 0, 0);
      step(0, 0, '0, 0, 1);
      if (b_type == 8'h01) acr_seen++;
    end
    chk("acr_count", acr_seen, m_acr_cnt);
    // 62 cycles of period 8 give 7 wraps, each served by the next selection.
    chk("acr_count_expected", acr_seen, 7);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
           {$urandom(), $urandom()} & {(2 * W){1'b1}},
           $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
